// File: rtl/subsistema_display_mux.sv
// subsistema_display_mux: time-multiplexed seven-segment driver for a packed BCD word.
// Captures resultadoBCD on the rising edge of banderaConvertida, acknowledges with a
// one-cycle pulse, flags non-decimal nibbles and scans the digits onto a shared bus.
// Optional build macro: SUPRESION_CEROS_EN blanks leading zeros (digit 0 always shown).
// Ports:
//   reloj, reinicio    clock, asynchronous active-high reset
//   resultadoBCD       packed BCD, digit k at [4k+3:4k]
//   banderaConvertida  data-ready level from the converter
//   banderaAceptada    one-cycle capture acknowledge
//   segmentos          {a,b,c,d,e,f,g}, bit 6 = a
//   anodos             one-hot digit enable, bit k = digit k
//   errorBCD           captured word holds a nibble > 9
module subsistema_display_mux #(
  parameter int unsigned DIGITOS     = 4,
  parameter int unsigned DIVISOR     = 50000,
  parameter int unsigned ACTIVO_BAJO = 1
) (
  input  logic                   reloj,
  input  logic                   reinicio,
  input  logic [4*DIGITOS-1:0]   resultadoBCD,
  input  logic                   banderaConvertida,
  output logic                   banderaAceptada,
  output logic [6:0]             segmentos,
  output logic [DIGITOS-1:0]     anodos,
  output logic                   errorBCD
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic        INV = (ACTIVO_BAJO != 0);

  logic [CW-1:0]        cuenta;
  logic [IW-1:0]        indice;
  logic [4*DIGITOS-1:0] dato;
  logic                 valido;
  logic                 previa;
  logic                 arranque;   // first cycle after reset: a level already high is not an edge
  logic                 pendiente;  // delays the acknowledge by one cycle after capture

  logic                 captura;
  logic                 error_c;
  logic [3:0]           nibble;
  logic                 suprimido;
  logic                 blanco;
  logic [6:0]           seg_c;
  logic [DIGITOS-1:0]   an_c;

  // Active-high segment pattern for one nibble; A-F show a dash.
  function automatic logic [6:0] decodificar(input logic [3:0] n);
    case (n)
      4'd0:    decodificar = 7'b1111110;
      4'd1:    decodificar = 7'b0110000;
      4'd2:    decodificar = 7'b1101101;
      4'd3:    decodificar = 7'b1111001;
      4'd4:    decodificar = 7'b0110011;
      4'd5:    decodificar = 7'b1011011;
      4'd6:    decodificar = 7'b1011111;
      4'd7:    decodificar = 7'b1110000;
      4'd8:    decodificar = 7'b1111111;
      4'd9:    decodificar = 7'b1111011;
      default: decodificar = 7'b0000001;
    endcase
  endfunction

  assign captura = banderaConvertida & ~previa & ~arranque;

  // Any non-decimal nibble in the held word.
  always_comb begin
    error_c = 1'b0;
    for (int k = 0; k < int'(DIGITOS); k++) begin
      if (dato[4*k +: 4] > 4'd9) error_c = 1'b1;
    end
  end

`ifdef SUPRESION_CEROS_EN
  logic [DIGITOS-1:0] suprimir;
  logic               cola;

  // Digit k>0 is suppressed when it and every more-significant digit are zero.
  always_comb begin
    suprimir = '0;
    cola     = 1'b1;
    for (int k = int'(DIGITOS) - 1; k >= 1; k--) begin
      cola        = cola & (dato[4*k +: 4] == 4'd0);
      suprimir[k] = cola;
    end
  end
`endif

  // Select the nibble and enable for the digit currently addressed by indice.
  always_comb begin
    nibble    = 4'd0;
    suprimido = 1'b0;
    an_c      = '0;
    for (int k = 0; k < int'(DIGITOS); k++) begin
      if (indice == IW'(k)) begin
        nibble  = dato[4*k +: 4];
        an_c[k] = 1'b1;
`ifdef SUPRESION_CEROS_EN
        suprimido = suprimir[k];
`endif
      end
    end
    blanco = ~valido | suprimido;
    seg_c  = blanco ? 7'd0 : decodificar(nibble);
    if (blanco) an_c = '0;
  end

  // Edge detect, capture, acknowledge, prescaler, digit scan and output registers.
  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      cuenta          <= '0;
      indice          <= '0;
      dato            <= '0;
      valido          <= 1'b0;
      previa          <= 1'b0;
      arranque        <= 1'b1;
      pendiente       <= 1'b0;
      banderaAceptada <= 1'b0;
      errorBCD        <= 1'b0;
      segmentos       <= {7{INV}};
      anodos          <= {DIGITOS{INV}};
    end else begin
      arranque        <= 1'b0;
      previa          <= banderaConvertida;
      pendiente       <= captura;
      banderaAceptada <= pendiente;
      errorBCD        <= error_c;
      if (captura) begin
        dato   <= resultadoBCD;
        valido <= 1'b1;
      end
      if (cuenta == CW'(DIVISOR - 1)) begin
        cuenta <= '0;
        if (indice == IW'(DIGITOS - 1)) indice <= '0;
        else                            indice <= indice + IW'(1);
      end else begin
        cuenta <= cuenta + CW'(1);
      end
      segmentos <= seg_c ^ {7{INV}};
      anodos    <= an_c ^ {DIGITOS{INV}};
    end
  end

endmodule
